// File: rtl/ov5640_cfg_pkg.sv
// rtl/ov5640_cfg_pkg.sv - shared types for the OV5640 init sequencer; OV5640_CFG_READBACK_EN adds the READBACK state
package ov5640_cfg_pkg;

   localparam logic [15:0] CFG_DELAY_MARKER = 16'hFFFF;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_PWRUP    = 4'd1,
      ST_FETCH    = 4'd2,
      ST_DECODE   = 4'd3,
      ST_WRITE    = 4'd4,
      ST_DELAY    = 4'd5,
      ST_NEXT     = 4'd6,
      ST_DONE     = 4'd7,
`ifdef OV5640_CFG_READBACK_EN
      ST_FAIL     = 4'd8,
      ST_READBACK = 4'd9
`else
      ST_FAIL     = 4'd8
`endif
   } cfg_state_e;

   typedef struct packed {
      logic [15:0] sub_addr;
      logic [7:0]  data;
   } cfg_entry_t;

   function automatic logic is_delay_entry(input cfg_entry_t e);
      return e.sub_addr == CFG_DELAY_MARKER;
   endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// rtl/cfg_delay_timer.sv - loadable down-counter shared by power-up wait and table delay entries
module cfg_delay_timer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic [31:0] count_i,
   output logic        expired_o
);

   logic [31:0] count_q;

   // A loaded value N keeps expired_o low for N cycles, then holds at zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= count_i;
      end else if (count_q != 32'd0) begin
         count_q <= count_q - 32'd1;
      end
   end

   assign expired_o = (count_q == 32'd0);

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// rtl/ov5640_cfg_sequencer.sv - walks an init table into SCCB writes with delays and retries
// OV5640_CFG_READBACK_EN: verify each write with an SCCB read of the same register
module ov5640_cfg_sequencer
   import ov5640_cfg_pkg::*;
#(
   parameter int         TABLE_LEN      = 256,
   parameter logic [7:0] DEVICE_ADDR    = 8'h78,
   parameter int         POWERUP_CYCLES = 20_000_000,
   parameter int         DELAY_UNIT     = 50_000,
   parameter int         MAX_RETRY      = 3
) (
   input  logic        clk,
   input  logic        rest_n,
   input  logic        start,
   output logic [9:0]  rom_addr,
   input  logic [23:0] rom_data,
   output logic [7:0]  sccb_device_addr,
   output logic [15:0] sccb_sub_addr,
   output logic        sccb_read,
   output logic        sccb_write,
   output logic [7:0]  sccb_write_data,
   input  logic        sccb_request_done,
   input  logic [7:0]  sccb_read_data,
   input  logic        sccb_resp_valid,
   input  logic        sccb_error,
   output logic        busy,
   output logic        cfg_done,
   output logic        cfg_error,
   output logic [9:0]  fail_index
);

   localparam int          RW          = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
   localparam logic [9:0]  LAST_IDX    = 10'(TABLE_LEN - 1);
   localparam logic [31:0] PWRUP_LOAD  = (POWERUP_CYCLES > 0) ? 32'(POWERUP_CYCLES - 1) : 32'd0;

   cfg_state_e      state_q;
   logic [9:0]      idx_q;
   logic [RW-1:0]   retry_q;
   cfg_entry_t      entry_q;
   logic [7:0]      dev_q;
   logic            wr_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic [9:0]      fail_idx_q;

   cfg_entry_t      rom_entry;
   logic [31:0]     delay_cycles;
   logic            start_ok;
   logic            tmr_load_d;
   logic [31:0]     tmr_count_d;
   logic            tmr_expired;
   logic            attempt_done;
   logic            attempt_fail;
   cfg_state_e      after_ok;

   assign rom_entry    = rom_data;
   assign delay_cycles = 32'(rom_entry.data) * 32'(DELAY_UNIT);
   assign start_ok     = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FAIL);

   // The timer is loaded one cycle early so the state it gates lasts exactly the requested count.
   always_comb begin
      tmr_load_d  = 1'b0;
      tmr_count_d = 32'd0;
      if (start_ok) begin
         tmr_load_d  = 1'b1;
         tmr_count_d = PWRUP_LOAD;
      end else if (state_q == ST_DECODE && is_delay_entry(rom_entry)) begin
         tmr_load_d  = 1'b1;
         tmr_count_d = (delay_cycles == 32'd0) ? 32'd0 : delay_cycles - 32'd1;
      end
   end

   cfg_delay_timer u_timer (
      .clk_i     (clk),
      .rst_ni    (rest_n),
      .load_i    (tmr_load_d),
      .count_i   (tmr_count_d),
      .expired_o (tmr_expired)
   );

`ifdef OV5640_CFG_READBACK_EN
   logic rd_q;
   logic rb_armed_q;
   logic rb_match_q;
   logic rb_ok_now;

   assign rb_ok_now    = sccb_resp_valid ? (sccb_read_data == entry_q.data) : rb_match_q;
   assign attempt_done = sccb_request_done &&
                         (state_q == ST_WRITE || (state_q == ST_READBACK && rb_armed_q));
   assign attempt_fail = sccb_error || (state_q == ST_READBACK && !rb_ok_now);
   assign after_ok     = (state_q == ST_WRITE) ? ST_READBACK : ST_NEXT;
   assign sccb_read    = rd_q;
`else
   logic unused_rb;

   assign attempt_done = sccb_request_done && state_q == ST_WRITE;
   assign attempt_fail = sccb_error;
   assign after_ok     = ST_NEXT;
   assign sccb_read    = 1'b0;
   assign unused_rb    = ^{sccb_read_data, sccb_resp_valid};
`endif

   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         retry_q    <= '0;
         entry_q    <= '0;
         dev_q      <= '0;
         wr_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         fail_idx_q <= '0;
`ifdef OV5640_CFG_READBACK_EN
         rd_q       <= 1'b0;
         rb_armed_q <= 1'b0;
         rb_match_q <= 1'b0;
`endif
      end else if (attempt_done) begin
         wr_q <= 1'b0;
`ifdef OV5640_CFG_READBACK_EN
         rd_q       <= 1'b0;
         rb_armed_q <= 1'b0;
`endif
         if (!attempt_fail) begin
            state_q <= after_ok;
         end else if (retry_q == RETRY_LIMIT) begin
            state_q    <= ST_FAIL;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            fail_idx_q <= idx_q;
         end else begin
            // Going back through FETCH guarantees a request-free cycle before the reissue.
            retry_q <= retry_q + RW'(1);
            state_q <= ST_FETCH;
         end
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (start) begin
                  state_q    <= ST_PWRUP;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  fail_idx_q <= '0;
                  idx_q      <= '0;
                  retry_q    <= '0;
               end
            end
            ST_PWRUP: begin
               if (tmr_expired) state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               entry_q <= rom_entry;
               if (is_delay_entry(rom_entry)) begin
                  state_q <= ST_DELAY;
               end else begin
                  state_q <= ST_WRITE;
                  wr_q    <= 1'b1;
                  dev_q   <= DEVICE_ADDR;
               end
            end
            ST_WRITE: begin
               state_q <= ST_WRITE;
            end
`ifdef OV5640_CFG_READBACK_EN
            ST_READBACK: begin
               // First cycle stays quiet so the read never follows request_done directly.
               if (!rb_armed_q) begin
                  rb_armed_q <= 1'b1;
                  rd_q       <= 1'b1;
                  rb_match_q <= 1'b0;
               end else if (sccb_resp_valid) begin
                  rb_match_q <= (sccb_read_data == entry_q.data);
               end
            end
`endif
            ST_DELAY: begin
               if (tmr_expired) state_q <= ST_NEXT;
            end
            ST_NEXT: begin
               retry_q <= '0;
               if (idx_q == LAST_IDX) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + 10'd1;
                  state_q <= ST_FETCH;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rom_addr         = idx_q;
   assign sccb_device_addr = dev_q;
   assign sccb_sub_addr    = entry_q.sub_addr;
   assign sccb_write_data  = entry_q.data;
   assign sccb_write       = wr_q;
   assign busy             = busy_q;
   assign cfg_done         = done_q;
   assign cfg_error        = err_q;
   assign fail_index       = fail_idx_q;

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// tb/tb_ov5640_cfg_sequencer.sv - scoreboard bench for the OV5640 init sequencer
module tb_ov5640_cfg_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rest_n;
   logic        m_start, s_start;
   logic [9:0]  m_rom_addr, s_rom_addr, m_fidx, s_fidx;
   logic [23:0] m_rom_data, s_rom_data;
   logic [7:0]  m_dev, s_dev, m_wdata, s_wdata, m_rdata, s_rdata;
   logic [15:0] m_sub, s_sub;
   logic        m_read, m_write, s_read, s_write;
   logic        m_done_p, m_rvalid, m_err, s_done_p, s_rvalid, s_err;
   logic        m_busy, m_cfg_done, m_cfg_err, s_busy, s_cfg_done, s_cfg_err;

   logic [23:0] m_tbl [0:7];
   logic [23:0] s_tbl [0:3];
   logic [23:0] m_exp [$];
   logic [23:0] s_exp [$];

   int tests = 0, fails = 0;
   int m_cyc = 0, m_wcycles = 0, s_hs = 0;
   int hs_t [int];
   int rise_t [int];
   logic [15:0] nack_sub = 16'h0, rb_bad_sub = 16'h0;
   int nack_left = 0, rb_bad_left = 0;

   ov5640_cfg_sequencer #(.TABLE_LEN(8), .DEVICE_ADDR(8'h78), .POWERUP_CYCLES(10),
                          .DELAY_UNIT(5), .MAX_RETRY(3)) dut (
      .clk(clk), .rest_n(rest_n), .start(m_start), .rom_addr(m_rom_addr), .rom_data(m_rom_data),
      .sccb_device_addr(m_dev), .sccb_sub_addr(m_sub), .sccb_read(m_read), .sccb_write(m_write),
      .sccb_write_data(m_wdata), .sccb_request_done(m_done_p), .sccb_read_data(m_rdata),
      .sccb_resp_valid(m_rvalid), .sccb_error(m_err), .busy(m_busy), .cfg_done(m_cfg_done),
      .cfg_error(m_cfg_err), .fail_index(m_fidx));

   ov5640_cfg_sequencer #(.TABLE_LEN(3), .DEVICE_ADDR(8'h78), .POWERUP_CYCLES(10),
                          .DELAY_UNIT(5), .MAX_RETRY(3)) dut_s (
      .clk(clk), .rest_n(rest_n), .start(s_start), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
      .sccb_device_addr(s_dev), .sccb_sub_addr(s_sub), .sccb_read(s_read), .sccb_write(s_write),
      .sccb_write_data(s_wdata), .sccb_request_done(s_done_p), .sccb_read_data(s_rdata),
      .sccb_resp_valid(s_rvalid), .sccb_error(s_err), .busy(s_busy), .cfg_done(s_cfg_done),
      .cfg_error(s_cfg_err), .fail_index(s_fidx));

   always @(posedge clk) begin
      m_rom_data <= m_tbl[m_rom_addr[2:0]];
      s_rom_data <= s_tbl[s_rom_addr[1:0]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic push_m(input logic [15:0] sub, input logic [7:0] data, input int n);
      for (int i = 0; i < n; i++) m_exp.push_back({sub, data});
   endtask

   task automatic pulse_m();
      @(posedge clk); #1 m_start = 1'b1;
      @(posedge clk); #1 m_start = 1'b0;
   endtask

   task automatic wait_m_end(input string name);
      int n;
      n = 0;
      while (!(m_cfg_done || m_cfg_err) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_finished"}, m_cfg_done | m_cfg_err, 1);
   endtask

   // Main SCCB controller model: request_done two cycles after a request rises.
   initial begin
      int lat;
      logic [7:0] last_w;
      lat = 0; last_w = 8'h0;
      m_done_p = 0; m_err = 0; m_rvalid = 0; m_rdata = 8'h0;
      forever begin
         @(posedge clk); #1;
         m_done_p = 0; m_err = 0; m_rvalid = 0;
         if (!rest_n || !(m_write || m_read)) begin
            lat = 0;
         end else begin
            lat++;
            if (lat == 3) begin
               lat = 0;
               m_done_p = 1;
               if (m_write) begin
                  if (m_sub == nack_sub && nack_left > 0) begin
                     m_err = 1;
                     nack_left--;
                  end else begin
                     last_w = m_wdata;
                  end
               end else begin
                  m_rvalid = 1;
                  if (m_sub == rb_bad_sub && rb_bad_left > 0) begin
                     m_rdata = 8'h00;
                     rb_bad_left--;
                  end else begin
                     m_rdata = last_w;
                  end
               end
            end
         end
      end
   end

   initial begin
      int lat;
      lat = 0;
      s_done_p = 0; s_err = 0; s_rvalid = 0; s_rdata = 8'h0;
      forever begin
         @(posedge clk); #1;
         s_done_p = 0; s_rvalid = 0;
         if (!rest_n || !(s_write || s_read)) lat = 0;
         else if (++lat == 3) begin
            lat = 0;
            s_done_p = 1;
            s_rvalid = s_read;
            s_rdata  = s_wdata;
         end
      end
   end

   // Main monitor: pops the scoreboard on every write handshake.
   initial begin
      logic prev_hs, prev_w;
      logic [23:0] e;
      prev_hs = 0; prev_w = 0;
      forever begin
         @(negedge clk);
         m_cyc++;
         if (m_write) m_wcycles++;
         if (prev_hs) check("no_reassert_after_done", m_write | m_read, 0);
         if (m_write && !prev_w && !rise_t.exists(int'(m_sub))) rise_t[int'(m_sub)] = m_cyc;
         prev_hs = rest_n && m_done_p && (m_write || m_read);
         if (rest_n && m_done_p && m_write) begin
            hs_t[int'(m_sub)] = m_cyc;
            if (m_exp.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_write: got sub 0x%h, expected no write", m_sub);
            end else begin
               e = m_exp.pop_front();
               check("wr_sub_addr", m_sub, e[23:8]);
               check("wr_data", m_wdata, e[7:0]);
               check("wr_device_addr", m_dev, 8'h78);
               check("wr_read_exclusive", m_read, 0);
            end
         end
         prev_w = m_write;
      end
   end

   initial begin
      logic [23:0] e;
      forever begin
         @(negedge clk);
         if (rest_n && s_done_p && s_write) begin
            s_hs++;
            if (s_exp.size() == 0) begin
               tests++; fails++;
               $display("FAIL small_unexpected_write: got sub 0x%h, expected no write", s_sub);
            end else begin
               e = s_exp.pop_front();
               check("small_wr_sub_addr", s_sub, e[23:8]);
               check("small_wr_data", s_wdata, e[7:0]);
            end
         end
      end
   end

   initial begin
      int n, w0;
      rest_n = 0; m_start = 0; s_start = 0;
      m_tbl[0] = {16'h3008, 8'h11}; m_tbl[1] = {16'hFFFF, 8'd4};
      m_tbl[2] = {16'h3103, 8'h22}; m_tbl[3] = {16'hFFFF, 8'd0};
      m_tbl[4] = {16'h3017, 8'h44}; m_tbl[5] = {16'h3018, 8'h55};
      m_tbl[6] = {16'h4300, 8'h66}; m_tbl[7] = {16'h3035, 8'h77};
      s_tbl[0] = {16'h5000, 8'hA0}; s_tbl[1] = {16'h5001, 8'hA1};
      s_tbl[2] = {16'h5002, 8'hA2}; s_tbl[3] = {16'h0000, 8'h00};
      repeat (3) @(negedge clk);
      check("rst_rom_addr", m_rom_addr, 0);
      check("rst_sub_addr", m_sub, 0);
      check("rst_write_data", m_wdata, 0);
      check("rst_device_addr", m_dev, 0);
      check("rst_sccb_rw", {m_read, m_write}, 0);
      check("rst_busy_done_err", {m_busy, m_cfg_done, m_cfg_err}, 0);
      check("rst_fail_index", m_fidx, 0);
      rest_n = 1;

      // Three-entry table, all ACK
      s_exp.push_back({16'h5000, 8'hA0}); s_exp.push_back({16'h5001, 8'hA1});
      s_exp.push_back({16'h5002, 8'hA2});
      @(posedge clk); #1 s_start = 1;
      @(posedge clk); #1 s_start = 0;
      n = 0;
      while (!s_cfg_done && n < 2000) begin @(negedge clk); n++; end
      check("small_done", s_cfg_done, 1);
      check("small_busy_err", {s_busy, s_cfg_err}, 0);
      check("small_handshakes", s_hs, 3);
      check("small_queue_left", s_exp.size(), 0);
      check("small_fail_index", s_fidx, 0);

      // Delay entries plus entry 2 NACKing twice
      nack_sub = 16'h3103; nack_left = 2;
      hs_t.delete(); rise_t.delete();
      push_m(16'h3008, 8'h11, 1); push_m(16'h3103, 8'h22, 3); push_m(16'h3017, 8'h44, 1);
      push_m(16'h3018, 8'h55, 1); push_m(16'h4300, 8'h66, 1); push_m(16'h3035, 8'h77, 1);
      pulse_m();
      @(negedge clk);
      check("run1_busy_after_start", m_busy, 1);
      wait_m_end("run1");
      check("run1_done", m_cfg_done, 1);
      check("run1_busy_err", {m_busy, m_cfg_err}, 0);
      check("run1_queue_left", m_exp.size(), 0);
      check("run1_nacks_used", nack_left, 0);
      check_range("delay4_gap", rise_t[16'h3103] - hs_t[16'h3008] - 1, 20, 34);
      check_range("delay0_gap", rise_t[16'h3017] - hs_t[16'h3103] - 1, 1, 14);

      // Entry 5 always NACKs
      nack_sub = 16'h3018; nack_left = 1000;
      push_m(16'h3008, 8'h11, 1); push_m(16'h3103, 8'h22, 1); push_m(16'h3017, 8'h44, 1);
      push_m(16'h3018, 8'h55, 4);
      pulse_m();
      @(negedge clk);
      check("run2_done_cleared", m_cfg_done, 0);
      wait_m_end("run2");
      check("run2_error", m_cfg_err, 1);
      check("run2_done", m_cfg_done, 0);
      check("run2_busy", m_busy, 0);
      check("run2_fail_index", m_fidx, 5);
      check("run2_attempts", 1000 - nack_left, 4);
      check("run2_queue_left", m_exp.size(), 0);

      // Reset while entry 4 is being written
      nack_left = 0;
      push_m(16'h3008, 8'h11, 1); push_m(16'h3103, 8'h22, 1);
      pulse_m();
      @(negedge clk);
      check("run3_restart_flags", {m_busy, m_cfg_err}, 2'b10);
      check("run3_fail_index_cleared", m_fidx, 0);
      n = 0;
      while (!(m_write && m_sub == 16'h3017) && n < 4000) begin @(negedge clk); n++; end
      check("run3_reached_entry4", m_sub, 16'h3017);
      rest_n = 0;
      #1;
      check("run3_reset_write", m_write, 0);
      check("run3_reset_busy", m_busy, 0);
      check("run3_reset_rom_addr", m_rom_addr, 0);
      repeat (2) @(negedge clk);
      rest_n = 1;
      w0 = m_wcycles;
      repeat (40) @(negedge clk);
      check("run3_no_restart", m_wcycles - w0, 0);
      check("run3_idle_flags", {m_busy, m_cfg_done, m_cfg_err}, 0);
      check("run3_queue_left", m_exp.size(), 0);

      // Fresh start replays from entry 0
      push_m(16'h3008, 8'h11, 1); push_m(16'h3103, 8'h22, 1); push_m(16'h3017, 8'h44, 1);
      push_m(16'h3018, 8'h55, 1); push_m(16'h4300, 8'h66, 1); push_m(16'h3035, 8'h77, 1);
      pulse_m();
      wait_m_end("run4");
      check("run4_done", m_cfg_done, 1);
      check("run4_queue_left", m_exp.size(), 0);

`ifdef OV5640_CFG_READBACK_EN
      // Readback of entry 0 returns 00 once: entry 0 is written twice
      rb_bad_sub = 16'h3008; rb_bad_left = 1;
      push_m(16'h3008, 8'h11, 2); push_m(16'h3103, 8'h22, 1); push_m(16'h3017, 8'h44, 1);
      push_m(16'h3018, 8'h55, 1); push_m(16'h4300, 8'h66, 1); push_m(16'h3035, 8'h77, 1);
      pulse_m();
      wait_m_end("run5");
      check("run5_done", m_cfg_done, 1);
      check("run5_bad_reads_used", rb_bad_left, 0);
      check("run5_queue_left", m_exp.size(), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ov5640_cfg_sequencer.md
OV5640_CFG_SEQUENCER -- requirements
Module: ov5640_cfg_sequencer

Interface
REQ-001 The block SHALL provide parameter TABLE_LEN, default 256, meaning the number of init-table entries (1..1024).
REQ-002 The block SHALL provide parameter DEVICE_ADDR, default 8'h78, meaning the 8-bit SCCB write address of the sensor.
REQ-003 The block SHALL provide parameter POWERUP_CYCLES, default 20_000_000, meaning the clk cycles to wait after start before the first transaction.
REQ-004 The block SHALL provide parameter DELAY_UNIT, default 50_000, meaning the clk cycles per delay-entry tick.
REQ-005 The block SHALL provide parameter MAX_RETRY, default 3, meaning the retries per entry after the first attempt.
REQ-006 The block SHALL provide these ports, clock and reset first:
- clk  in  1  sole clock.
- rest_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins configuration; ignored unless idle.
- rom_addr  out  10  table index.
- rom_data  in  24  {sub_addr[15:0], data[7:0]}, valid one cycle after rom_addr.
- sccb_device_addr  out  8  to controller device_addr.
- sccb_sub_addr  out  16  to controller sub_addr.
- sccb_read  out  1  to controller read.
- sccb_write  out  1  to controller write.
- sccb_write_data  out  8  to controller write_data.
- sccb_request_done  in  1  controller completion pulse.
- sccb_read_data  in  8  controller read data.
- sccb_resp_valid  in  1  controller read-data strobe.
- sccb_error  in  1  controller NACK flag, sampled with request_done.
- busy  out  1  high from accepted start until DONE or FAIL.
- cfg_done  out  1  level, set on successful completion.
- cfg_error  out  1  level, set on abort.
- fail_index  out  10  entry index that aborted.

Function
REQ-007 The FSM SHALL have states IDLE, PWRUP, FETCH, DECODE, WRITE, READBACK, DELAY, NEXT, DONE, FAIL.
REQ-008 IDLE SHALL move to PWRUP on start; a start in DONE or FAIL SHALL clear cfg_done/cfg_error/fail_index and restart from entry 0.
REQ-009 PWRUP SHALL count POWERUP_CYCLES clk cycles and then go to FETCH with rom_addr=0.
REQ-010 FETCH SHALL drive rom_addr for one cycle; DECODE SHALL register rom_data.
REQ-011 An entry with sub_addr==16'hFFFF SHALL go to DELAY for data*DELAY_UNIT cycles with no SCCB traffic; data==0 SHALL mean zero wait, taking one cycle.
REQ-012 Any other entry SHALL go to WRITE, asserting sccb_write with stable sub_addr/write_data/device_addr=DEVICE_ADDR until the cycle sccb_request_done is seen high, then deassert in the following cycle.
REQ-013 sccb_read and sccb_write SHALL never be high together, and SHALL NOT be reasserted in the cycle after request_done.
REQ-014 When request_done arrives with sccb_error=1, the entry SHALL be reissued. After MAX_RETRY failed retries, i.e. MAX_RETRY+1 attempts, the FSM SHALL go to FAIL with fail_index = the entry index.
REQ-015 The retry counter SHALL be cleared on every entry advance.
REQ-016 NEXT SHALL increment the index and go to DONE when index==TABLE_LEN-1, otherwise to FETCH; the index SHALL NOT wrap.
REQ-017 DONE SHALL set cfg_done=1 and busy=0. FAIL SHALL set cfg_error=1 and busy=0. Both SHALL hold until reset or start.
REQ-018 A request_done arriving while no request is outstanding SHALL be ignored.

Reset
REQ-019 rest_n low SHALL asynchronously force IDLE, counters 0, rom_addr 0, all sccb_* outputs 0, busy/cfg_done/cfg_error 0, and fail_index 0.
REQ-020 Reset mid-transaction SHALL drop sccb_write/sccb_read immediately, and the block SHALL NOT restart until a new start.

Configuration
REQ-021 With macro OV5640_CFG_READBACK_EN defined, each successful write SHALL be followed by READBACK, which asserts sccb_read for the same sub_addr. It SHALL compare sccb_read_data at sccb_resp_valid against data; a mismatch or error SHALL count as a failed attempt of that entry per REQ-014.
REQ-022 Without OV5640_CFG_READBACK_EN, the READBACK state SHALL NOT exist, sccb_read SHALL be tied 0, and sccb_read_data/sccb_resp_valid SHALL be unused.

Structure
REQ-023 Package ov5640_cfg_pkg SHALL hold the FSM state enum, the entry struct {sub_addr, data}, and constant CFG_DELAY_MARKER=16'hFFFF.
REQ-024 The PWRUP and DELAY counting SHALL be one shared sub-module, cfg_delay_timer, with inputs load+count and output expired.

Verification
REQ-025 The bench SHALL cover: TABLE_LEN=3, all ACK, POWERUP_CYCLES=10 -> exactly 3 write handshakes to sub_addr of entries 0..2, then cfg_done=1 and busy=0.
REQ-026 The bench SHALL cover: entry 1 = {16'hFFFF, 8'd4}, DELAY_UNIT=5 -> 20 cycles with no sccb_write between entries 0 and 2.
REQ-027 The bench SHALL cover: entry 2 NACKs twice then ACKs, MAX_RETRY=3 -> 3 writes of entry 2, and cfg_done=1.
REQ-028 The bench SHALL cover: entry 5 always NACKs, MAX_RETRY=3 -> 4 attempts, then cfg_error=1 and fail_index=5.
REQ-029 The bench SHALL cover: rest_n pulsed low during an entry-4 write -> sccb_write=0 in the same cycle and IDLE; the next start replays from entry 0.
REQ-030 The bench SHALL cover, with OV5640_CFG_READBACK_EN: readback returns 8'h00 versus written 8'h11 -> a retry of the same entry.
